// File: rtl/spi_xfer_datapath.sv
// SPI transfer datapath: TX/RX FIFOs around a runtime-configurable frame shift engine.
// The engine owns bit counting; the controller only supplies start, sample and shift ticks.

module spi_xfer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_rd,
    output logic [W-1:0]     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_nxt;
    logic [W-1:0]     w_head_next;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_pop    = i_rd && !o_empty;
    assign w_push   = i_wr && (!o_full || w_pop);
    assign w_rd_nxt = r_rd_ptr + 1'b1;
    assign o_head   = r_head;
    assign o_count  = r_count;

    // Head is registered so it keeps its last value once the FIFO drains.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_count > CNT_W'(1))
                w_head_next = r_mem[w_rd_nxt];
            else if (w_push)
                w_head_next = i_wdata;
        end else if (o_empty && w_push) begin
            w_head_next = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            r_head <= w_head_next;
        end
    end

    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

module spi_xfer_datapath #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    parameter int FL_W       = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miso_i,
    output logic              mosi_o,
    input  logic              xfer_start_i,
    input  logic              sample_tick_i,
    input  logic              shift_tick_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [FL_W-1:0]   frame_len_i,
    output logic              busy_o,
    output logic              frame_done_o,
    input  logic              tx_wr_i,
    input  logic [DATA_W-1:0] tx_wdata_i,
    output logic              tx_full_o,
    output logic              tx_empty_o,
    output logic [CNT_W-1:0]  tx_count_o,
    input  logic              rx_rd_i,
    output logic [DATA_W-1:0] rx_rdata_o,
    output logic              rx_full_o,
    output logic              rx_empty_o,
    output logic [CNT_W-1:0]  rx_count_o,
    input  logic [CNT_W-1:0]  tx_wmark_i,
    input  logic [CNT_W-1:0]  rx_wmark_i,
    output logic              tx_wmark_o,
    output logic              rx_wmark_o,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o,
    input  logic              err_clr_i
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COMMIT} state_t;

    state_t            r_state, w_state_next;
    logic [FL_W-1:0]   r_len, r_bit_cnt, w_len_eff, w_bit_cnt_inc;
    logic              r_cpha, r_lsb, r_mosi;
    logic [DATA_W-1:0] r_tx_sr, r_rx_sr;
    logic [DATA_W-1:0] w_tx_head, w_tx_mask, w_tx_word, w_tx_aligned;
    logic              w_start, w_sample, w_last, w_shift, w_tx_pop, w_rx_push;
    logic              r_tx_wmark, r_rx_wmark, r_tx_underrun, r_rx_overrun;

    assign w_len_eff = (frame_len_i == '0 || frame_len_i > FL_W'(DATA_W)) ? FL_W'(DATA_W)
                                                                           : frame_len_i;
    assign w_start       = (r_state == ST_IDLE) && xfer_start_i;
    assign w_sample      = (r_state == ST_ACTIVE) && sample_tick_i;
    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
    assign w_last        = w_sample && (w_bit_cnt_inc == r_len);
    // With cpha=0 the first bit is already out, so shifts only count once sampling has begun.
    assign w_shift       = (r_state == ST_ACTIVE) && shift_tick_i && !w_last &&
                           (r_cpha || (r_bit_cnt != '0) || w_sample);
    assign w_tx_pop      = w_start && !tx_empty_o;
    assign w_rx_push     = (r_state == ST_COMMIT);

    // MSB-first words are left-aligned so the next bit is always at the top of the register.
    assign w_tx_mask    = ~({DATA_W{1'b1}} << w_len_eff);
    assign w_tx_word    = tx_empty_o ? '0 : (w_tx_head & w_tx_mask);
    assign w_tx_aligned = lsb_first_i ? w_tx_word : (w_tx_word << (FL_W'(DATA_W) - w_len_eff));

    spi_xfer_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk(clk), .rst(rst), .i_wr(tx_wr_i), .i_wdata(tx_wdata_i), .i_rd(w_tx_pop),
        .o_head(w_tx_head), .o_count(tx_count_o), .o_full(tx_full_o), .o_empty(tx_empty_o)
    );

    spi_xfer_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk(clk), .rst(rst), .i_wr(w_rx_push), .i_wdata(r_rx_sr), .i_rd(rx_rd_i),
        .o_head(rx_rdata_o), .o_count(rx_count_o), .o_full(rx_full_o), .o_empty(rx_empty_o)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (xfer_start_i) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_last) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len         <= '0;
            r_bit_cnt     <= '0;
            r_cpha        <= 1'b0;
            r_lsb         <= 1'b0;
            r_mosi        <= 1'b0;
            r_tx_sr       <= '0;
            r_rx_sr       <= '0;
            r_tx_wmark    <= 1'b0;
            r_rx_wmark    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            if (w_start) begin
                r_len     <= w_len_eff;
                r_cpha    <= cpha_i;
                r_lsb     <= lsb_first_i;
                r_rx_sr   <= '0;
                r_bit_cnt <= '0;
                if (cpha_i) begin
                    r_tx_sr <= w_tx_aligned;
                    r_mosi  <= 1'b0;
                end else begin
                    r_tx_sr <= lsb_first_i ? (w_tx_aligned >> 1) : (w_tx_aligned << 1);
                    r_mosi  <= lsb_first_i ? w_tx_aligned[0] : w_tx_aligned[DATA_W-1];
                end
            end
            if (w_sample) begin
                r_bit_cnt <= w_bit_cnt_inc;
                r_rx_sr   <= r_lsb ? ((r_rx_sr >> 1) | (DATA_W'(miso_i) << (r_len - 1'b1)))
                                   : {r_rx_sr[DATA_W-2:0], miso_i};
            end
            if (w_shift) begin
                r_mosi  <= r_lsb ? r_tx_sr[0] : r_tx_sr[DATA_W-1];
                r_tx_sr <= r_lsb ? (r_tx_sr >> 1) : (r_tx_sr << 1);
            end
            if (r_state == ST_COMMIT) r_mosi <= 1'b0;

            r_tx_underrun <= (w_start && tx_empty_o) || (r_tx_underrun && !err_clr_i);
            r_rx_overrun  <= (w_rx_push && rx_full_o && !rx_rd_i) || (r_rx_overrun && !err_clr_i);
            r_tx_wmark    <= (tx_count_o < tx_wmark_i);
            r_rx_wmark    <= (rx_count_o >= rx_wmark_i);
        end
    end

    assign mosi_o        = r_mosi;
    assign busy_o        = (r_state != ST_IDLE);
    assign frame_done_o  = (r_state == ST_COMMIT);
    assign tx_wmark_o    = r_tx_wmark;
    assign rx_wmark_o    = r_rx_wmark;
    assign tx_underrun_o = r_tx_underrun;
    assign rx_overrun_o  = r_rx_overrun;
endmodule

// File: tb/tb_spi_xfer_datapath.sv
// Directed self-checking bench for spi_xfer_datapath (DATA_W=8, FIFO_DEPTH=8).
`timescale 1ns/1ps

module tb_spi_xfer_datapath;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FL_W       = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              miso_i, mosi_o;
    logic              xfer_start_i, sample_tick_i, shift_tick_i, cpha_i, lsb_first_i;
    logic [FL_W-1:0]   frame_len_i;
    logic              busy_o, frame_done_o;
    logic              tx_wr_i;
    logic [DATA_W-1:0] tx_wdata_i;
    logic              tx_full_o, tx_empty_o;
    logic [CNT_W-1:0]  tx_count_o;
    logic              rx_rd_i;
    logic [DATA_W-1:0] rx_rdata_o;
    logic              rx_full_o, rx_empty_o;
    logic [CNT_W-1:0]  rx_count_o;
    logic [CNT_W-1:0]  tx_wmark_i, rx_wmark_i;
    logic              tx_wmark_o, rx_wmark_o, tx_underrun_o, rx_overrun_o, err_clr_i;
    logic              loopback, miso_val;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    assign miso_i = loopback ? mosi_o : miso_val;

    spi_xfer_datapath #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .miso_i(miso_i), .mosi_o(mosi_o),
        .xfer_start_i(xfer_start_i), .sample_tick_i(sample_tick_i), .shift_tick_i(shift_tick_i),
        .cpha_i(cpha_i), .lsb_first_i(lsb_first_i), .frame_len_i(frame_len_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o),
        .tx_wr_i(tx_wr_i), .tx_wdata_i(tx_wdata_i), .tx_full_o(tx_full_o),
        .tx_empty_o(tx_empty_o), .tx_count_o(tx_count_o),
        .rx_rd_i(rx_rd_i), .rx_rdata_o(rx_rdata_o), .rx_full_o(rx_full_o),
        .rx_empty_o(rx_empty_o), .rx_count_o(rx_count_o),
        .tx_wmark_i(tx_wmark_i), .rx_wmark_i(rx_wmark_i),
        .tx_wmark_o(tx_wmark_o), .rx_wmark_o(rx_wmark_o),
        .tx_underrun_o(tx_underrun_o), .rx_overrun_o(rx_overrun_o), .err_clr_i(err_clr_i)
    );

    // Inputs change and outputs are observed 1ns after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [DATA_W-1:0] d);
        tx_wr_i = 1'b1; tx_wdata_i = d; cyc(); tx_wr_i = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd_i = 1'b1; cyc(); rx_rd_i = 1'b0;
    endtask

    // Runs one frame with alternating ticks; returns at frame-done + 1 (back in IDLE).
    task automatic run_frame(input logic [FL_W-1:0] len, input logic lsb, input logic cpha,
                             input bit do_start, input logic clr_at_start,
                             output int n_samp, output logic [DATA_W-1:0] bits);
        bit done;
        done = 1'b0; n_samp = 0; bits = '0;
        frame_len_i = len; lsb_first_i = lsb; cpha_i = cpha;
        if (do_start) begin
            xfer_start_i = 1'b1; err_clr_i = clr_at_start; cyc();
            xfer_start_i = 1'b0; err_clr_i = 1'b0;
        end
        for (int i = 0; i < 2 * DATA_W + 4 && !done; i++) begin
            if (cpha) begin shift_tick_i = 1'b1; cyc(); shift_tick_i = 1'b0; end
            bits = {bits[DATA_W-2:0], mosi_o};
            sample_tick_i = 1'b1; cyc(); sample_tick_i = 1'b0;
            n_samp++;
            if (frame_done_o) done = 1'b1;
            else if (!cpha) begin shift_tick_i = 1'b1; cyc(); shift_tick_i = 1'b0; end
        end
        n_total++;
        if (!done) $display("FAIL frame_timeout: frame_done=%b after %0d samples, want 1", done, n_samp);
        else n_pass++;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); cyc();
        n_total++;
        if ({mosi_o, busy_o, frame_done_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
             tx_wmark_o, rx_wmark_o, tx_underrun_o, rx_overrun_o} !== 11'b00001010000 ||
            {tx_count_o, rx_count_o, rx_rdata_o} !== '0)
            $display("FAIL reset_state: flags=%b counts=%0d/%0d rdata=%h, want 00001010000 0/0 00",
                     {mosi_o, busy_o, frame_done_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
                      tx_wmark_o, rx_wmark_o, tx_underrun_o, rx_overrun_o},
                     tx_count_o, rx_count_o, rx_rdata_o);
        else n_pass++;
        rst = 1'b0; cyc();
    endtask

    task automatic test_msb_cpha0();
        logic [DATA_W-1:0] obs;
        int done_cnt;
        obs = '0; done_cnt = 0;
        push_tx(8'hA5);
        loopback = 1'b1; frame_len_i = 4'd8; lsb_first_i = 1'b0; cpha_i = 1'b0;
        xfer_start_i = 1'b1; cyc(); xfer_start_i = 1'b0;
        n_total++;
        if ({busy_o, tx_count_o, mosi_o} !== {1'b1, 4'd0, 1'b1})
            $display("FAIL msb_start: busy=%b txcnt=%0d mosi=%b, want 1 0 1", busy_o, tx_count_o, mosi_o);
        else n_pass++;
        // Mid-frame config changes and a stray start (TX now empty) must all be ignored.
        frame_len_i = 4'd3; lsb_first_i = 1'b1; cpha_i = 1'b1; xfer_start_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            obs = {obs[DATA_W-2:0], mosi_o};
            sample_tick_i = 1'b1; shift_tick_i = (i == 7);
            cyc();
            sample_tick_i = 1'b0; shift_tick_i = 1'b0; xfer_start_i = 1'b0;
            if (frame_done_o) done_cnt++;
            if (i < 7) begin
                shift_tick_i = 1'b1; cyc(); shift_tick_i = 1'b0;
                if (frame_done_o) done_cnt++;
            end
        end
        n_total++;
        if (obs !== 8'hA5) $display("FAIL msb_mosi_seq: got %h want a5", obs);
        else n_pass++;
        n_total++;
        if ({frame_done_o, busy_o, mosi_o} !== 3'b111)
            $display("FAIL msb_commit: done=%b busy=%b mosi=%b, want 1 1 1 (last shift ignored)",
                     frame_done_o, busy_o, mosi_o);
        else n_pass++;
        cyc();
        n_total++;
        if ({frame_done_o, busy_o, rx_count_o, rx_rdata_o, tx_underrun_o} !== {2'b00, 4'd1, 8'hA5, 1'b0} ||
            done_cnt != 1)
            $display("FAIL msb_result: done=%b busy=%b rxcnt=%0d rdata=%h underrun=%b pulses=%0d, want 0 0 1 a5 0 1",
                     frame_done_o, busy_o, rx_count_o, rx_rdata_o, tx_underrun_o, done_cnt);
        else n_pass++;
        pop_rx();
        n_total++;
        if ({rx_count_o, rx_empty_o} !== {4'd0, 1'b1})
            $display("FAIL msb_pop: rxcnt=%0d empty=%b, want 0 1", rx_count_o, rx_empty_o);
        else n_pass++;
    endtask

    task automatic test_lsb_cpha1();
        int ns;
        logic [DATA_W-1:0] bits;
        push_tx(8'hF3);
        loopback = 1'b0; miso_val = 1'b1;
        run_frame(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, ns, bits);
        n_total++;
        if (ns != 5 || bits[4:0] !== 5'b11001)
            $display("FAIL lsb_mosi_seq: samples=%0d bits=%b, want 5 11001", ns, bits[4:0]);
        else n_pass++;
        n_total++;
        if ({rx_count_o, rx_rdata_o} !== {4'd1, 8'h1F})
            $display("FAIL lsb_rx_word: rxcnt=%0d rdata=%h, want 1 1f", rx_count_o, rx_rdata_o);
        else n_pass++;
        pop_rx();
    endtask

    task automatic test_underrun();
        int ns;
        logic [DATA_W-1:0] bits;
        loopback = 1'b0; miso_val = 1'b0;
        // err_clr_i coincides with the underrun being raised: the set must win.
        run_frame(4'd4, 1'b0, 1'b0, 1'b1, 1'b1, ns, bits);
        n_total++;
        if (tx_underrun_o !== 1'b1 || ns != 4 || bits[3:0] !== 4'b0000)
            $display("FAIL underrun_frame: underrun=%b samples=%0d bits=%b, want 1 4 0000",
                     tx_underrun_o, ns, bits[3:0]);
        else n_pass++;
        n_total++;
        if ({rx_count_o, rx_rdata_o} !== {4'd1, 8'h00})
            $display("FAIL underrun_rx: rxcnt=%0d rdata=%h, want 1 00", rx_count_o, rx_rdata_o);
        else n_pass++;
        err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
        n_total++;
        if (tx_underrun_o !== 1'b0) $display("FAIL underrun_clear: got %b want 0", tx_underrun_o);
        else n_pass++;
        pop_rx();
    endtask

    task automatic test_overrun();
        int ns;
        logic [DATA_W-1:0] bits;
        loopback = 1'b0; miso_val = 1'b0;
        run_frame(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ns, bits);
        n_total++;
        if (ns != 8) $display("FAIL len_zero_is_full: samples=%0d want 8", ns);
        else n_pass++;
        miso_val = 1'b1;
        for (int f = 1; f < FIFO_DEPTH; f++) run_frame(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ns, bits);
        cyc();
        n_total++;
        if ({rx_count_o, rx_full_o, rx_wmark_o, rx_overrun_o, rx_rdata_o} !== {4'd8, 3'b110, 8'h00})
            $display("FAIL rx_fill: cnt=%0d full=%b wmark=%b ovr=%b head=%h, want 8 1 1 0 00",
                     rx_count_o, rx_full_o, rx_wmark_o, rx_overrun_o, rx_rdata_o);
        else n_pass++;
        run_frame(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ns, bits);
        n_total++;
        if ({rx_overrun_o, rx_count_o, rx_rdata_o} !== {1'b1, 4'd8, 8'h00})
            $display("FAIL rx_overrun: ovr=%b cnt=%0d head=%h, want 1 8 00",
                     rx_overrun_o, rx_count_o, rx_rdata_o);
        else n_pass++;
        // Nine pops: the last one hits an empty FIFO and must leave the head word alone.
        rx_rd_i = 1'b1;
        repeat (FIFO_DEPTH + 1) cyc();
        rx_rd_i = 1'b0;
        n_total++;
        if ({rx_count_o, rx_empty_o, rx_rdata_o} !== {4'd0, 1'b1, 8'hFF})
            $display("FAIL rx_drain: cnt=%0d empty=%b rdata=%h, want 0 1 ff",
                     rx_count_o, rx_empty_o, rx_rdata_o);
        else n_pass++;
        err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
        n_total++;
        if ({tx_underrun_o, rx_overrun_o} !== 2'b00)
            $display("FAIL err_clear: underrun=%b overrun=%b, want 0 0", tx_underrun_o, rx_overrun_o);
        else n_pass++;
    endtask

    task automatic test_tx_wmark();
        int ns;
        logic [DATA_W-1:0] bits;
        tx_wmark_i = 4'd4; loopback = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) push_tx(8'h10 + 8'(i));
        push_tx(8'hEE);
        cyc(); cyc();
        n_total++;
        if ({tx_count_o, tx_full_o, tx_wmark_o} !== {4'd8, 1'b1, 1'b0})
            $display("FAIL tx_full: cnt=%0d full=%b wmark=%b, want 8 1 0", tx_count_o, tx_full_o, tx_wmark_o);
        else n_pass++;
        for (int f = 0; f < 4; f++) run_frame(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, ns, bits);
        n_total++;
        if ({tx_count_o, tx_wmark_o} !== {4'd4, 1'b0})
            $display("FAIL tx_wmark_at4: cnt=%0d wmark=%b, want 4 0", tx_count_o, tx_wmark_o);
        else n_pass++;
        frame_len_i = 4'd8; lsb_first_i = 1'b0; cpha_i = 1'b0;
        xfer_start_i = 1'b1; cyc(); xfer_start_i = 1'b0;
        n_total++;
        if ({tx_count_o, tx_wmark_o} !== {4'd3, 1'b0})
            $display("FAIL tx_wmark_lag: cnt=%0d wmark=%b, want 3 0", tx_count_o, tx_wmark_o);
        else n_pass++;
        cyc();
        n_total++;
        if (tx_wmark_o !== 1'b1) $display("FAIL tx_wmark_rise: got %b want 1", tx_wmark_o);
        else n_pass++;
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, ns, bits);
        n_total++;
        if (bits !== 8'h14 || {rx_count_o, rx_rdata_o} !== {4'd5, 8'h10})
            $display("FAIL tx_order: bits=%h rxcnt=%0d head=%h, want 14 5 10", bits, rx_count_o, rx_rdata_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ns;
        logic [DATA_W-1:0] bits;
        frame_len_i = 4'd8; lsb_first_i = 1'b0; cpha_i = 1'b0; loopback = 1'b1;
        xfer_start_i = 1'b1; cyc(); xfer_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_tick_i = 1'b1; cyc(); sample_tick_i = 1'b0;
            shift_tick_i = 1'b1; cyc(); shift_tick_i = 1'b0;
        end
        rst = 1'b1; cyc();
        n_total++;
        if ({mosi_o, busy_o, frame_done_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
             tx_wmark_o, rx_wmark_o, tx_underrun_o, rx_overrun_o} !== 11'b00001010000 ||
            {tx_count_o, rx_count_o, rx_rdata_o} !== '0)
            $display("FAIL mid_reset: flags=%b counts=%0d/%0d rdata=%h, want 00001010000 0/0 00",
                     {mosi_o, busy_o, frame_done_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
                      tx_wmark_o, rx_wmark_o, tx_underrun_o, rx_overrun_o},
                     tx_count_o, rx_count_o, rx_rdata_o);
        else n_pass++;
        rst = 1'b0; cyc(); cyc(); cyc();
        n_total++;
        if ({rx_count_o, busy_o} !== {4'd0, 1'b0})
            $display("FAIL mid_reset_no_push: rxcnt=%0d busy=%b, want 0 0", rx_count_o, busy_o);
        else n_pass++;
        push_tx(8'h81);
        run_frame(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, ns, bits);
        n_total++;
        if (bits !== 8'h81 || {rx_count_o, rx_rdata_o} !== {4'd1, 8'h81})
            $display("FAIL post_reset_frame: bits=%h rxcnt=%0d rdata=%h, want 81 1 81",
                     bits, rx_count_o, rx_rdata_o);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; xfer_start_i = 1'b0; sample_tick_i = 1'b0; shift_tick_i = 1'b0;
        cpha_i = 1'b0; lsb_first_i = 1'b0; frame_len_i = 4'd8;
        tx_wr_i = 1'b0; tx_wdata_i = '0; rx_rd_i = 1'b0;
        tx_wmark_i = 4'd0; rx_wmark_i = 4'd8; err_clr_i = 1'b0;
        loopback = 1'b0; miso_val = 1'b0;
        test_reset();
        test_msb_cpha0();
        test_lsb_cpha1();
        test_underrun();
        test_overrun();
        test_tx_wmark();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200 us");
        $fatal(1);
    end
endmodule
